// File: rtl/led_drv_pkg.sv
// Shared types and elaboration-time helpers for the LED shift-register driver.
package led_drv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    // Counter width for values 0..v-1; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int latch_cyc(input int clk_div);
        return 2 * clk_div;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shift-clock phase divider: one-cycle tick every CLK_DIV cycles, realigned by i_restart.
module led_tick_gen
    import led_drv_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= LOAD;
        end else if (i_restart || cnt == '0) begin
            cnt <= LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_tick = (cnt == '0);

endmodule

// File: rtl/led_shift_driver.sv
// Serial driver for 74HC595-style chains: shifts CHANNELS words out on a shared
// divided shift clock, then strobes the storage latch.
module led_shift_driver
    import led_drv_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CHANNELS     = 1,
    parameter int CLK_DIV      = 2,
    parameter int LSB_FIRST    = 0,
    parameter int AUTO_REFRESH = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [CHANNELS*DATA_W-1:0]   i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [CHANNELS-1:0]          o_LEDdata,
    output logic                         o_LEDclk,
    output logic                         o_LEDlatch,
    output logic                         o_done
);

    localparam int BW = clog2(DATA_W);
    localparam int LW = clog2(latch_cyc(CLK_DIV));
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(latch_cyc(CLK_DIV) - 1);

    state_t                       state, state_n;
    logic [CHANNELS*DATA_W-1:0]   shadow, src;
    logic                         loaded;
    logic                         accept, start, tick;
    logic [BW-1:0]                bit_idx, bit_n, sel;
    logic [LW-1:0]                lat_cnt;
    logic [CHANNELS-1:0]          data_n;

    led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (start),
        .o_tick    (tick)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    start   = 1'b1;
                    state_n = SHIFT_LO;
                end else if (AUTO_REFRESH != 0 && loaded) begin
                    start   = 1'b1;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: if (tick) state_n = SHIFT_HI;
            SHIFT_HI: if (tick) state_n = (bit_idx == BIT_LAST) ? LATCH : SHIFT_LO;
            LATCH:    if (lat_cnt == LAT_LAST) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Bit index for the coming cycle, so the data line is registered alongside the clock.
    always_comb begin
        bit_n = bit_idx;
        if (start) begin
            bit_n = '0;
        end else if (state == SHIFT_HI && tick && bit_idx != BIT_LAST) begin
            bit_n = bit_idx + 1'b1;
        end
    end

    assign sel = (LSB_FIRST != 0) ? bit_n : (BIT_LAST - bit_n);
    // On the accept edge the shadow is not yet loaded, so the first bit comes straight from i_data.
    assign src = accept ? i_data : shadow;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] chan;
        assign chan      = src[c*DATA_W +: DATA_W];
        assign data_n[c] = chan[sel];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            shadow     <= '0;
            loaded     <= 1'b0;
            bit_idx    <= '0;
            lat_cnt    <= '0;
            o_LEDdata  <= '0;
            o_LEDclk   <= 1'b0;
            o_LEDlatch <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_n;
            if (accept) begin
                shadow <= i_data;
                loaded <= 1'b1;
            end
            lat_cnt    <= (state == LATCH && state_n == LATCH) ? lat_cnt + 1'b1 : '0;
            o_LEDclk   <= (state_n == SHIFT_HI);
            o_LEDlatch <= (state_n == LATCH);
            o_LEDdata  <= (state_n == SHIFT_LO || state_n == SHIFT_HI) ? data_n : '0;
            o_done     <= (state == LATCH && state_n == IDLE);
        end
    end

    assign o_ready = (state == IDLE);

endmodule

// File: tb/tb_led_shift_driver.sv
// Two driver configurations checked against a 595-chain model and a frame scoreboard.
module tb_led_shift_driver;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic        rst      [2];
    logic        valid    [2];
    logic [31:0] data     [2];
    logic        ready    [2];
    logic        ledclk   [2];
    logic        ledlatch [2];
    logic        done     [2];
    logic [1:0]  leddata  [2];

    typedef struct {
        logic [31:0] w;
        int          acc;
    } exp_t;

    // dut_a: MSB first, CLK_DIV=2, no refresh. dut_b: LSB first, CLK_DIV=1, auto-refresh.
    led_shift_driver #(.DATA_W(DW), .CHANNELS(2), .CLK_DIV(2), .LSB_FIRST(0), .AUTO_REFRESH(0)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_valid(valid[0]), .o_ready(ready[0]),
        .o_LEDdata(leddata[0]), .o_LEDclk(ledclk[0]), .o_LEDlatch(ledlatch[0]), .o_done(done[0]));

    led_shift_driver #(.DATA_W(DW), .CHANNELS(2), .CLK_DIV(1), .LSB_FIRST(1), .AUTO_REFRESH(1)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_valid(valid[1]), .o_ready(ready[1]),
        .o_LEDdata(leddata[1]), .o_LEDclk(ledclk[1]), .o_LEDlatch(ledlatch[1]), .o_done(done[1]));

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What a 595 chain holds after DW shifts: first bit sent lands in the top position.
    function automatic logic [31:0] lat_model(input logic [31:0] w, input bit lsb);
        logic [31:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i]      = lsb ? w[DW-1-i]   : w[i];
            r[DW + i] = lsb ? w[2*DW-1-i] : w[DW + i];
        end
        return r;
    endfunction

    for (genvar u = 0; u < 2; u++) begin : mon
        localparam int CD    = (u == 0) ? 2 : 1;
        localparam bit LSB   = (u == 1);
        localparam bit AR    = (u == 1);
        localparam int FRAME = 2 * CD * (DW + 1);

        exp_t        q[$];
        logic [15:0] sr0 = '0, sr1 = '0;
        logic [31:0] latched = '0, last = '0;
        int          nshift = 0, latlen = 0, lowcnt = 0, ndone = 0, last_done = 0;
        bit          loaded = 0, prev_clk = 0, prev_lat = 0, prev_done = 0;

        always @(negedge clk) begin
            if (rst[u]) begin
                q.delete();
                nshift = 0; latlen = 0; lowcnt = 0; loaded = 0;
                prev_clk = 0; prev_lat = 0; prev_done = 0;
            end else begin
                if (ledclk[u] && !prev_clk) begin
                    if (nshift == 0 && q.size() > 0)
                        check($sformatf("u%0d_first_rise", u), cyc, q[0].acc + CD);
                    sr0 = {sr0[14:0], leddata[u][0]};
                    sr1 = {sr1[14:0], leddata[u][1]};
                    nshift++;
                end
                if (ledlatch[u]) latlen++;
                if (ledlatch[u] && !prev_lat) begin
                    check($sformatf("u%0d_shift_count", u), nshift, DW);
                    check($sformatf("u%0d_latch_quiet", u), {ledclk[u], leddata[u]}, 0);
                    latched = {sr1, sr0};
                    nshift  = 0;
                end
                if (!ledlatch[u] && prev_lat) begin
                    check($sformatf("u%0d_latch_len", u), latlen, 2 * CD);
                    latlen = 0;
                end
                if (done[u]) begin
                    if (prev_done) check($sformatf("u%0d_done_width", u), 2, 1);
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL u%0d_done_unexpected: got o_done=1 expected no frame pending", u);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check($sformatf("u%0d_word", u), latched, lat_model(e.w, LSB));
                        check($sformatf("u%0d_done_time", u), cyc, e.acc + FRAME);
                    end
                    ndone++;
                    last_done = cyc;
                end
                // Reference: frames start from IDLE on a new word, or re-send the last one.
                if (ready[u]) begin
                    if (lowcnt != 0) check($sformatf("u%0d_busy_len", u), lowcnt, FRAME);
                    lowcnt = 0;
                    if (valid[u]) begin
                        q.push_back('{w: data[u], acc: cyc + 1});
                        last = data[u]; loaded = 1;
                    end else if (AR && loaded) begin
                        q.push_back('{w: last, acc: cyc + 1});
                    end
                end else begin
                    lowcnt++;
                end
                prev_clk  = ledclk[u];
                prev_lat  = ledlatch[u];
                prev_done = done[u];
            end
        end
    end

    function automatic int qsize(input int u);
        return (u == 0) ? mon[0].q.size() : mon[1].q.size();
    endfunction

    function automatic int ndone_of(input int u);
        return (u == 0) ? mon[0].ndone : mon[1].ndone;
    endfunction

    task automatic send(input int u, input logic [31:0] d, input bit keep, output int acc);
        bit ok;
        int t;
        data[u] = d; valid[u] = 1'b1; t = 0;
        do begin
            ok = ready[u];
            @(posedge clk); #1;
            t++;
        end while (!ok && t < 300);
        check($sformatf("u%0d_accepted", u), ok, 1);
        acc = cyc;
        if (!keep) valid[u] = 1'b0;
    endtask

    task automatic wait_drain(input int u);
        int t;
        t = 0;
        while (qsize(u) != 0 && t < 1000) begin @(negedge clk); t++; end
        check($sformatf("u%0d_drain", u), qsize(u), 0);
    endtask

    task automatic wait_done(input int u, input int n);
        int t, s;
        t = 0; s = ndone_of(u);
        while (ndone_of(u) < s + n && t < 1000) begin @(negedge clk); t++; end
        check($sformatf("u%0d_done_count", u), ndone_of(u) - s, n);
    endtask

    task automatic check_idle_outputs(input int u, input string tag);
        check($sformatf("u%0d_%s_data", u, tag), leddata[u], 0);
        check($sformatf("u%0d_%s_clk", u, tag), ledclk[u], 0);
        check($sformatf("u%0d_%s_latch", u, tag), ledlatch[u], 0);
        check($sformatf("u%0d_%s_done", u, tag), done[u], 0);
        check($sformatf("u%0d_%s_ready", u, tag), ready[u], 1);
    endtask

    task automatic run_a();
        int acc, t;
        send(0, {16'hA5A5, 16'h0001}, 0, acc); wait_drain(0);
        send(0, {16'h0000, 16'h00FF}, 0, acc); wait_drain(0);
        // valid held across frames: second word must be taken in the single IDLE cycle
        send(0, {16'h5555, 16'h1234}, 1, acc);
        send(0, {16'hAAAA, 16'hFFFF}, 0, acc);
        check("u0_b2b_gap", acc, mon[0].last_done + 1);
        wait_drain(0);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(0, $urandom, ($urandom_range(0, 1) == 1), acc);
        end
        valid[0] = 1'b0;
        wait_drain(0);
        // asynchronous reset part-way through a frame
        send(0, {16'h3C3C, 16'h1357}, 0, acc);
        t = 0;
        while (mon[0].nshift < 5 && t < 500) begin @(negedge clk); t++; end
        check("u0_reached_5_rises", mon[0].nshift >= 5, 1);
        #2 rst[0] = 1'b1;
        #1 check_idle_outputs(0, "midrst");
        @(posedge clk); @(negedge clk); #1;
        rst[0] = 1'b0;
        #1 check_idle_outputs(0, "postrst");
        send(0, {16'h0000, 16'hBEEF}, 0, acc); wait_drain(0);
    endtask

    task automatic run_b();
        int acc, n0;
        send(1, {16'h3C3C, 16'h0F0F}, 0, acc);
        wait_done(1, 3);
        send(1, {16'h5A5A, 16'h00AA}, 0, acc);
        wait_done(1, 3);
        for (int i = 0; i < 3; i++) begin
            send(1, $urandom, 0, acc);
            wait_done(1, 2);
        end
        // reset clears the loaded flag, so refresh must stop
        @(posedge clk); #2;
        rst[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst[1] = 1'b0;
        n0 = ndone_of(1);
        repeat (40) @(posedge clk);
        #1;
        check("u1_no_refresh_after_reset", ndone_of(1), n0);
        check_idle_outputs(1, "parked");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; valid[u] = 1'b0; data[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) check_idle_outputs(u, "reset");
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;
        fork
            run_a();
            run_b();
        join
        check("u0_queue_empty", qsize(0), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
